// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: MIPS-style HI/LO mul/div sequencer with a radix-2 restoring divider
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        stall_m,
  input  logic [63:0] mul_prod,
  output logic        mul_sign,
  output logic        stall_e,
  output logic        res_valid,
  output logic [63:0] hilo,
  output logic        hilo_we
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [1:0]  op_r;
  logic [31:0] a_r, b_r, d, rem, q, a_abs, b_abs, rem_n, q_n, q_f, r_f;
  logic [32:0] tmp, diff;
  logic [5:0]  cnt;
  logic        accept, ge, neg_q, neg_r, last;
  assign accept = state == IDLE && start && !flush;
  assign a_abs  = (!op[0] && a[31]) ? -a : a;
  assign b_abs  = (!op[0] && b[31]) ? -b : b;
  assign last   = cnt == 6'd31;
  // One restoring step: shift the next dividend bit in, subtract if it fits
  always_comb begin
    tmp   = {rem, q[31]};
    diff  = tmp - {1'b0, d};
    ge    = !diff[32];
    rem_n = ge ? diff[31:0] : tmp[31:0];
    q_n   = {q[30:0], ge};
    neg_q = op_r == 2'b10 && (a_r[31] ^ b_r[31]);
    neg_r = op_r == 2'b10 && a_r[31];
    q_f   = neg_q ? -q_n : q_n;
    r_f   = neg_r ? -rem_n : rem_n;
  end
  // State register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // Next state; flush overrides everything, DONE waits for MEM to take the result
  always_comb begin
    state_n = flush ? IDLE
            : state == IDLE ? (accept ? (op[1] ? DIV : MUL) : IDLE)
            : state == MUL  ? DONE
            : state == DIV  ? ((b_r == '0 || last) ? DONE : DIV)
            : (stall_m ? DONE : IDLE);
  end
  // Operand capture, divider iteration and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r <= '0;
      a_r  <= '0;
      b_r  <= '0;
      d    <= '0;
      rem  <= '0;
      q    <= '0;
      cnt  <= '0;
      hilo <= '0;
    end else if (accept) begin
      op_r <= op;
      a_r  <= a;
      b_r  <= b;
      d    <= b_abs;
      rem  <= '0;
      q    <= a_abs;
      cnt  <= '0;
    end else if (state == MUL && !flush) begin
      hilo <= mul_prod;
    end else if (state == DIV && !flush) begin
      if (b_r == '0) begin
        hilo <= {a_r, 32'hFFFF_FFFF};
      end else begin
        rem <= rem_n;
        q   <= q_n;
        cnt <= cnt + 6'd1;
        if (last) hilo <= {r_f, q_f};
      end
    end
  end
  assign mul_sign  = (state == IDLE ? op : op_r) == 2'b00;
  assign stall_e   = !rst && (accept || state == MUL || state == DIV);
  assign res_valid = !rst && state == DONE && !flush;
  assign hilo_we   = res_valid && !stall_m;
endmodule
